// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the simple ALU system datapath.
//   - mulState_t : multiplier FSM encoding (IDLE=0, RUN=1, DONE=2)
//   - MUL_WIDTH  : default operand width of the sequential multiplier
//   - FUNSEL_LOAD: register FunSel code that loads the I input; the controller
//                  uses it on the Done cycle to capture the product low half
package alu_pkg;

  localparam int MUL_WIDTH = 16;

  localparam logic [2:0] FUNSEL_LOAD = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mulState_t;

endpackage

// File: rtl/mul_step.sv
// mul_step
//   One combinational iteration of the shift-add multiplier. When the multiplier
//   LSB is set, the multiplicand is added into the accumulator (the high half of
//   the running product) with the carry kept in a WIDTH+1-bit sum. The
//   {carry, acc, mplier} concatenation is then shifted right by one.
// Ports
//   acc        in   WIDTH  accumulator (product high half so far)
//   mplier     in   WIDTH  multiplier / product low half so far
//   mcand      in   WIDTH  multiplicand (unsigned magnitude)
//   accNext    out  WIDTH  accumulator after add and shift
//   mplierNext out  WIDTH  multiplier register after shift
import alu_pkg::*;

module mul_step #(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mplier,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] accNext,
  output logic [WIDTH-1:0] mplierNext
);

  logic [WIDTH:0] sum;

  // The sum's LSB falls into the top of the multiplier register, and the carry
  // becomes the new accumulator MSB, so no product bit is ever lost.
  always_comb begin
    sum        = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    accNext    = sum[WIDTH:1];
    mplierNext = {sum[0], mplier[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Multi-cycle shift-add multiplier with a Start/Busy/Done handshake. Operands
//   are sampled when Start is accepted in IDLE; WIDTH iterations run in RUN; the
//   product and flags are registered on the RUN->DONE edge and held until the
//   next completed operation. Done is a one-cycle pulse in DONE.
//   Optional feature: define MUL_SIGNED_EN to add the Signed input and two's
//   complement operation (magnitudes multiplied, product negated at DONE entry).
// Ports
//   Clock     in   1      rising-edge clock
//   Reset     in   1      asynchronous active-low reset
//   Start     in   1      operation request, accepted only in IDLE
//   Signed    in   1      (MUL_SIGNED_EN only) operands are two's complement
//   A         in   WIDTH  multiplicand
//   B         in   WIDTH  multiplier
//   Busy      out  1      high in RUN and DONE
//   Done      out  1      one-cycle completion pulse
//   Result    out  WIDTH  product low half
//   ResultHi  out  WIDTH  product high half
//   Z         out  1      whole 2*WIDTH product is zero
//   O         out  1      product does not fit in WIDTH bits
import alu_pkg::*;

module seq_multiplier #(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
`ifdef MUL_SIGNED_EN
  input  logic             Signed,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Z,
  output logic             O
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mulState_t state, nextState;

  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   accNext;
  logic [WIDTH-1:0]   mplierNext;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] finalProduct;
  logic               lastIter;
  logic               overflow;

  assign lastIter = (count == CW'(WIDTH - 1));

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mplier     (mplier),
    .mcand      (mcand),
    .accNext    (accNext),
    .mplierNext (mplierNext)
  );

`ifdef MUL_SIGNED_EN
  logic negSign;

  // Magnitudes are multiplied unsigned. The most negative operand 0x80..0 maps
  // onto itself, which is its correct magnitude read as an unsigned number.
  always_comb begin
    magA = (Signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
    magB = (Signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
  end

  // The final step's outputs form the finished magnitude product; the sign is
  // applied here so the registered result is already two's complement.
  always_comb begin
    finalProduct = {accNext, mplierNext};
    if (negSign) begin
      finalProduct = ~{accNext, mplierNext} + 1'b1;
    end
    overflow = (finalProduct[2*WIDTH-1:WIDTH] != {WIDTH{finalProduct[WIDTH-1]}});
  end

  // Sign of the product is captured alongside the operands.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      negSign <= 1'b0;
    end else if (state == IDLE && Start) begin
      negSign <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
    end
  end
`else
  // Unsigned only: the operands pass straight through and overflow means any
  // bit set in the high half.
  always_comb begin
    magA         = A;
    magB         = B;
    finalProduct = {accNext, mplierNext};
    overflow     = (accNext != '0);
  end
`endif

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake outputs. Start outside IDLE is simply not looked
  // at, so a request during an operation is dropped rather than queued.
  always_comb begin
    nextState = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          nextState = RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        if (lastIter) begin
          nextState = DONE;
        end
      end
      DONE: begin
        Busy      = 1'b1;
        Done      = 1'b1;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Datapath: operand capture on accepted Start, one shift-add per RUN cycle,
  // and result/flag capture on the last iteration so they appear with Done and
  // stay put afterwards. The counter stops at WIDTH-1 instead of wrapping.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count    <= '0;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      Result   <= '0;
      ResultHi <= '0;
      Z        <= 1'b0;
      O        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            mcand  <= magA;
            mplier <= magB;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= accNext;
          mplier <= mplierNext;
          if (lastIter) begin
            Result   <= finalProduct[WIDTH-1:0];
            ResultHi <= finalProduct[2*WIDTH-1:WIDTH];
            Z        <= (finalProduct == '0);
            O        <= overflow;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier
//   Self-checking bench for seq_multiplier. Expected products are computed with
//   wide integer arithmetic and pushed to a scoreboard queue when an operation
//   is started; each scenario pops and compares once Done has been seen.
//   Define MUL_SIGNED_EN to build the signed scenario as well.
module tb_seq_multiplier;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] A     = '0;
  logic [15:0] B     = '0;
  logic        Busy;
  logic        Done;
  logic [15:0] Result;
  logic [15:0] ResultHi;
  logic        Z;
  logic        O;
`ifdef MUL_SIGNED_EN
  logic        Signed = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        z;
    logic        o;
  } exp_t;

  exp_t sbq[$];

  always #5 Clock = ~Clock;

  seq_multiplier #(.WIDTH(16)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
`ifdef MUL_SIGNED_EN
    .Signed   (Signed),
`endif
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result),
    .ResultHi (ResultHi),
    .Z        (Z),
    .O        (O)
  );

  // Reference product from plain integer multiplication; overflow is judged by
  // whether the value lies outside the WIDTH-bit range.
  task automatic pushExpected(input logic [15:0] a, input logic [15:0] b, input bit sgn);
    longint p;
    exp_t   e;
    if (sgn) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      e.o = (p > 32767) || (p < -32768);
    end else begin
      p   = longint'(a) * longint'(b);
      e.o = (p > 65535);
    end
    e.lo = p[15:0];
    e.hi = p[31:16];
    e.z  = (p == 0);
    sbq.push_back(e);
  endtask

  // Presents a one-cycle Start; returns on the negedge after the accept edge.
  task automatic issueStart(input logic [15:0] a, input logic [15:0] b, input bit sgn);
    @(negedge Clock);
    A     = a;
    B     = b;
    Start = 1'b1;
`ifdef MUL_SIGNED_EN
    Signed = sgn;
`endif
    pushExpected(a, b, sgn);
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Samples on negedges until the operation has completed and Busy has fallen.
  // injectAt >= 0 re-asserts Start (with different operands) during Busy.
  task automatic waitDone(input int injectAt, output int busyCycles,
                          output int donePulses, output bit seen);
    busyCycles = 0;
    donePulses = 0;
    seen       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Busy) busyCycles++;
      if (Done) begin
        donePulses++;
        seen = 1'b1;
      end
      if (seen && !Busy) break;
      if (i == injectAt) begin
        A     = 16'h00FF;
        B     = 16'h00FF;
        Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clock);
    end
    Start = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: no Done within 40 cycles");
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    checks++;
    if ({Busy, Done, Z, O} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_flags: Busy/Done/Z/O=%b required 0000", {Busy, Done, Z, O});
    end
    checks++;
    if ({ResultHi, Result} !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_result: got %h required 00000000", {ResultHi, Result});
    end
    Reset = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_basic();
    int busyCycles, donePulses;
    bit seen;
    exp_t e;
    issueStart(16'h0003, 16'h0005, 1'b0);
    waitDone(-1, busyCycles, donePulses, seen);
    e = sbq.pop_front();
    checks++;
    if (busyCycles !== 17) begin
      failures++;
      $display("[TB] FAIL basic_busy_len: got %0d required 17", busyCycles);
    end
    checks++;
    if (donePulses !== 1) begin
      failures++;
      $display("[TB] FAIL basic_done_pulses: got %0d required 1", donePulses);
    end
    checks++;
    if (Result !== e.lo || ResultHi !== e.hi) begin
      failures++;
      $display("[TB] FAIL basic_product: got %h_%h required %h_%h", ResultHi, Result, e.hi, e.lo);
    end
    checks++;
    if (Z !== e.z || O !== e.o) begin
      failures++;
      $display("[TB] FAIL basic_flags: got Z=%b O=%b required Z=%b O=%b", Z, O, e.z, e.o);
    end
  endtask

  task automatic test_overflow();
    int busyCycles, donePulses;
    bit seen;
    exp_t e;
    issueStart(16'hFFFF, 16'hFFFF, 1'b0);
    waitDone(-1, busyCycles, donePulses, seen);
    e = sbq.pop_front();
    checks++;
    if (Result !== e.lo || ResultHi !== e.hi) begin
      failures++;
      $display("[TB] FAIL ovf_product: got %h_%h required %h_%h", ResultHi, Result, e.hi, e.lo);
    end
    checks++;
    if (Z !== e.z || O !== e.o) begin
      failures++;
      $display("[TB] FAIL ovf_flags: got Z=%b O=%b required Z=%b O=%b", Z, O, e.z, e.o);
    end
  endtask

  task automatic test_zero();
    int busyCycles, donePulses;
    bit seen;
    exp_t e;
    issueStart(16'h0000, 16'h1234, 1'b0);
    waitDone(-1, busyCycles, donePulses, seen);
    e = sbq.pop_front();
    checks++;
    if (Result !== e.lo || ResultHi !== e.hi) begin
      failures++;
      $display("[TB] FAIL zero_product: got %h_%h required %h_%h", ResultHi, Result, e.hi, e.lo);
    end
    checks++;
    if (Z !== e.z || O !== e.o) begin
      failures++;
      $display("[TB] FAIL zero_flags: got Z=%b O=%b required Z=%b O=%b", Z, O, e.z, e.o);
    end
    // Immediately follow with a non-zero product so Z must drop again.
    issueStart(16'h0002, 16'h0004, 1'b0);
    waitDone(-1, busyCycles, donePulses, seen);
    e = sbq.pop_front();
    checks++;
    if (Result !== e.lo || ResultHi !== e.hi) begin
      failures++;
      $display("[TB] FAIL after_zero_product: got %h_%h required %h_%h", ResultHi, Result, e.hi, e.lo);
    end
    checks++;
    if (Z !== e.z || O !== e.o) begin
      failures++;
      $display("[TB] FAIL after_zero_flags: got Z=%b O=%b required Z=%b O=%b", Z, O, e.z, e.o);
    end
  endtask

  task automatic test_ignore_start();
    int busyCycles, donePulses, lateBusy;
    bit seen;
    exp_t e;
    issueStart(16'h0123, 16'h0045, 1'b0);
    waitDone(4, busyCycles, donePulses, seen);
    e = sbq.pop_front();
    checks++;
    if (busyCycles !== 17) begin
      failures++;
      $display("[TB] FAIL ignore_busy_len: got %0d required 17", busyCycles);
    end
    checks++;
    if (donePulses !== 1) begin
      failures++;
      $display("[TB] FAIL ignore_done_pulses: got %0d required 1", donePulses);
    end
    checks++;
    if (Result !== e.lo || ResultHi !== e.hi) begin
      failures++;
      $display("[TB] FAIL ignore_product: got %h_%h required %h_%h", ResultHi, Result, e.hi, e.lo);
    end
    lateBusy = 0;
    repeat (4) begin
      @(negedge Clock);
      if (Busy) lateBusy++;
    end
    checks++;
    if (lateBusy !== 0) begin
      failures++;
      $display("[TB] FAIL ignore_not_queued: Busy seen %0d cycles required 0", lateBusy);
    end
    checks++;
    if (Result !== e.lo || ResultHi !== e.hi) begin
      failures++;
      $display("[TB] FAIL result_hold: got %h_%h required %h_%h", ResultHi, Result, e.hi, e.lo);
    end
  endtask

  task automatic test_async_reset();
    int busyCycles, donePulses, abortDone;
    bit seen;
    exp_t e;
    issueStart(16'h1234, 16'h5678, 1'b0);
    void'(sbq.pop_back());
    repeat (7) @(negedge Clock);
    #1 Reset = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, Z, O} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL async_reset_flags: Busy/Done/Z/O=%b required 0000", {Busy, Done, Z, O});
    end
    checks++;
    if ({ResultHi, Result} !== 32'h0) begin
      failures++;
      $display("[TB] FAIL async_reset_result: got %h required 00000000", {ResultHi, Result});
    end
    @(negedge Clock);
    Reset = 1'b1;
    abortDone = 0;
    repeat (20) begin
      @(negedge Clock);
      if (Done || Busy) abortDone++;
    end
    checks++;
    if (abortDone !== 0) begin
      failures++;
      $display("[TB] FAIL abort_no_done: activity seen %0d cycles required 0", abortDone);
    end
    issueStart(16'h0010, 16'h0010, 1'b0);
    waitDone(-1, busyCycles, donePulses, seen);
    e = sbq.pop_front();
    checks++;
    if (busyCycles !== 17) begin
      failures++;
      $display("[TB] FAIL post_reset_busy_len: got %0d required 17", busyCycles);
    end
    checks++;
    if (Result !== e.lo || ResultHi !== e.hi || Z !== e.z || O !== e.o) begin
      failures++;
      $display("[TB] FAIL post_reset_product: got %h_%h Z=%b O=%b required %h_%h Z=%b O=%b",
               ResultHi, Result, Z, O, e.hi, e.lo, e.z, e.o);
    end
  endtask

`ifdef MUL_SIGNED_EN
  task automatic test_signed();
    int busyCycles, donePulses;
    bit seen;
    exp_t e;
    issueStart(16'hFFFD, 16'h0005, 1'b1);
    waitDone(-1, busyCycles, donePulses, seen);
    e = sbq.pop_front();
    checks++;
    if (Result !== e.lo || ResultHi !== e.hi || Z !== e.z || O !== e.o) begin
      failures++;
      $display("[TB] FAIL signed_neg: got %h_%h Z=%b O=%b required %h_%h Z=%b O=%b",
               ResultHi, Result, Z, O, e.hi, e.lo, e.z, e.o);
    end
    checks++;
    if (busyCycles !== 17) begin
      failures++;
      $display("[TB] FAIL signed_busy_len: got %0d required 17", busyCycles);
    end
    issueStart(16'h8000, 16'h8000, 1'b1);
    waitDone(-1, busyCycles, donePulses, seen);
    e = sbq.pop_front();
    checks++;
    if (Result !== e.lo || ResultHi !== e.hi || Z !== e.z || O !== e.o) begin
      failures++;
      $display("[TB] FAIL signed_minneg: got %h_%h Z=%b O=%b required %h_%h Z=%b O=%b",
               ResultHi, Result, Z, O, e.hi, e.lo, e.z, e.o);
    end
    Signed = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_ignore_start();
    test_async_reset();
`ifdef MUL_SIGNED_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
